// File: rtl/ram_stream_pkg.sv
// Shared types and constants for the RAM stream reader.
// The output buffer depth is fixed at two to cover the one-cycle RAM read latency.
package ram_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BUF_DEPTH = 2;
    localparam int CNT_WIDTH = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/ram_stream_reader_if.sv
// RAM read port and output stream bundled for the reader.
// The master side drives the RAM address and the stream; the slave side is the RAM and consumer.
interface ram_stream_reader_if #(
    parameter int WORD_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);

    logic                  ram_we_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [WORD_WIDTH-1:0] ram_data_i;
    logic                  m_valid_o;
    logic [WORD_WIDTH-1:0] m_data_o;
    logic                  m_last_o;
    logic                  m_ready_i;

    modport master (
        output ram_we_o, ram_addr_o, m_valid_o, m_data_o, m_last_o,
        input  ram_data_i, m_ready_i
    );

    modport slave (
        input  ram_we_o, ram_addr_o, m_valid_o, m_data_o, m_last_o,
        output ram_data_i, m_ready_i
    );

endinterface

// File: rtl/ram_stream_fifo2.sv
// Two-entry register FIFO; the head entry is a register so the stream outputs come straight from flops.
// A push and a pop in the same cycle are accepted even when the FIFO is full.
module ram_stream_fifo2 import ram_stream_pkg::*; #(
    parameter int WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     dout,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_WIDTH-1:0] count
);

    logic [WIDTH-1:0]     head_r;
    logic [WIDTH-1:0]     tail_r;
    logic [CNT_WIDTH-1:0] count_r;
    logic                 push_ok_s;
    logic                 pop_ok_s;

    // Qualify requests against the current fill level.
    always_comb begin
        empty     = (count_r == {CNT_WIDTH{1'b0}});
        full      = (count_r == CNT_WIDTH'(BUF_DEPTH));
        pop_ok_s  = pop && !empty;
        push_ok_s = push && (!full || pop_ok_s);
    end

    // Storage and fill-level update; the head always holds the oldest entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {WIDTH{1'b0}};
            tail_r  <= {WIDTH{1'b0}};
            count_r <= {CNT_WIDTH{1'b0}};
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10: begin
                    if (count_r == {CNT_WIDTH{1'b0}}) begin
                        head_r <= din;
                    end else begin
                        tail_r <= din;
                    end
                    count_r <= count_r + CNT_WIDTH'(1);
                end
                2'b01: begin
                    head_r  <= tail_r;
                    count_r <= count_r - CNT_WIDTH'(1);
                end
                2'b11: begin
                    if (count_r == CNT_WIDTH'(1)) begin
                        head_r <= din;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= din;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign dout  = head_r;
    assign count = count_r;

endmodule

// File: rtl/ram_stream_reader_chk.sv
// Run-time property checks for the RAM stream reader; all checks are masked while reset is high.
// Stall history is kept in local registers so each property is a plain per-edge expression.
module ram_stream_reader_chk import ram_stream_pkg::*; #(
    parameter int WORD_WIDTH = 8,
    parameter int WORD_COUNT = 256,
    parameter int LEN_WIDTH  = 9
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  start,
    input logic                  busy,
    input logic [LEN_WIDTH-1:0]  len,
    input logic                  m_valid,
    input logic                  m_ready,
    input logic [WORD_WIDTH-1:0] m_data,
    input logic                  m_last,
    input logic                  push,
    input logic                  pop,
    input logic                  full,
    input logic [CNT_WIDTH-1:0]  count
);

    logic                  prev_stall_r;
    logic [WORD_WIDTH-1:0] prev_data_r;
    logic                  prev_last_r;

    // Remember whether the previous cycle held a beat that was not accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_stall_r <= 1'b0;
            prev_data_r  <= {WORD_WIDTH{1'b0}};
            prev_last_r  <= 1'b0;
        end else begin
            prev_stall_r <= m_valid && !m_ready;
            prev_data_r  <= m_data;
            prev_last_r  <= m_last;
        end
    end

    a_start_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(start))
        else $error("ram_stream_reader: start is unknown");

    a_len_legal: assert property (@(posedge clk) disable iff (rst)
        !(start && !busy) || (len <= LEN_WIDTH'(WORD_COUNT)))
        else $error("ram_stream_reader: len above WORD_COUNT");

    a_valid_stable: assert property (@(posedge clk) disable iff (rst)
        !prev_stall_r || (m_valid && (m_data == prev_data_r) && (m_last == prev_last_r)))
        else $error("ram_stream_reader: stalled beat changed or dropped");

    a_occupancy: assert property (@(posedge clk) disable iff (rst)
        count <= CNT_WIDTH'(BUF_DEPTH))
        else $error("ram_stream_reader: buffer occupancy above depth");

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && full && !pop))
        else $error("ram_stream_reader: push into full buffer");

endmodule

// File: rtl/ram_stream_reader.sv
// Streams len_i consecutive RAM words starting at base_addr_i out as a valid/ready stream.
// A read is only issued when the 2-entry buffer is guaranteed room for its data one cycle later.
module ram_stream_reader import ram_stream_pkg::*; #(
    parameter  int WORD_WIDTH = 8,
    parameter  int WORD_COUNT = 256,
    localparam int ADDR_WIDTH = $clog2(WORD_COUNT),
    localparam int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    ram_stream_reader_if.master   bus
);

    localparam int CREDIT_WIDTH = CNT_WIDTH + 1;

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] ptr_r;
    logic [LEN_WIDTH-1:0]  remaining_r;
    logic                  inflight_r;
    logic                  inflight_last_r;
    logic                  busy_r;
    logic                  done_r;

    logic [CNT_WIDTH-1:0]  fifo_count_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [WORD_WIDTH:0]   head_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  last_pop_s;
    logic                  issue_s;
    logic [ADDR_WIDTH-1:0] next_ptr_s;

    // Handshake decode, wrap-around address increment and issue credit.
    always_comb begin
        pop_s      = !fifo_empty_s && bus.m_ready_i;
        push_s     = inflight_r;
        last_pop_s = pop_s && head_s[WORD_WIDTH];
        if (ptr_r == ADDR_WIDTH'(WORD_COUNT - 1)) begin
            next_ptr_s = {ADDR_WIDTH{1'b0}};
        end else begin
            next_ptr_s = ptr_r + ADDR_WIDTH'(1);
        end
        // Slots already owed to the buffer are its occupancy plus the read still in flight.
        if ((state_r == RUN) && (remaining_r != {LEN_WIDTH{1'b0}}) &&
            ((({1'b0, fifo_count_s} + {{CNT_WIDTH{1'b0}}, inflight_r}) < CREDIT_WIDTH'(BUF_DEPTH)) ||
             pop_s)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Transfer FSM with read pointer, issue counter and registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r         <= IDLE;
            ptr_r           <= {ADDR_WIDTH{1'b0}};
            remaining_r     <= {LEN_WIDTH{1'b0}};
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            done_r     <= 1'b0;
            if (issue_s) begin
                ptr_r           <= next_ptr_s;
                remaining_r     <= remaining_r - LEN_WIDTH'(1);
                inflight_last_r <= (remaining_r == LEN_WIDTH'(1));
            end
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        ptr_r       <= base_addr_i;
                        remaining_r <= len_i;
                        busy_r      <= 1'b1;
                        if (len_i == {LEN_WIDTH{1'b0}}) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (last_pop_s) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    ram_stream_fifo2 #(
        .WIDTH (WORD_WIDTH + 1)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push_s),
        .pop   (pop_s),
        .din   ({inflight_last_r, bus.ram_data_i}),
        .dout  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    ram_stream_reader_chk #(
        .WORD_WIDTH (WORD_WIDTH),
        .WORD_COUNT (WORD_COUNT),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_chk (
        .clk     (clk_i),
        .rst     (rst_i),
        .start   (start_i),
        .busy    (busy_r),
        .len     (len_i),
        .m_valid (!fifo_empty_s),
        .m_ready (bus.m_ready_i),
        .m_data  (head_s[WORD_WIDTH-1:0]),
        .m_last  (head_s[WORD_WIDTH]),
        .push    (push_s),
        .pop     (pop_s),
        .full    (fifo_full_s),
        .count   (fifo_count_s)
    );

    assign bus.ram_we_o   = 1'b0;
    assign bus.ram_addr_o = ptr_r;
    assign bus.m_valid_o  = !fifo_empty_s;
    assign bus.m_data_o   = head_s[WORD_WIDTH-1:0];
    assign bus.m_last_o   = head_s[WORD_WIDTH];
    assign busy_o         = busy_r;
    assign done_o         = done_r;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader against a RAM preloaded with mem[i] = i.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ram_stream_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] len_in;
    logic       busy;
    logic       done;
    logic [7:0] mem [256];
    logic [7:0] ram_q;
    logic [15:0] rdy_pat = 16'b1100_0110_1011_1001;
    int tests = 0;
    int fails = 0;

    ram_stream_reader_if #(.WORD_WIDTH(8), .ADDR_WIDTH(8)) bus ();

    ram_stream_reader #(.WORD_WIDTH(8), .WORD_COUNT(256)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .base_addr_i (base_addr),
        .len_i       (len_in),
        .busy_o      (busy),
        .done_o      (done),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_q <= mem[bus.ram_addr_o];
    assign bus.ram_data_i = ram_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always high; mode 1: ready follows rdy_pat. inj>0 pulses a start at that cycle.
    task automatic run_xfer(input string tag, input int base, input int len, input int mode, input int inj);
        int cyc = 0;
        int beats = 0;
        int first_v = -1;
        int done_c = -1;
        logic rdy;
        logic prev_stall = 1'b0;
        logic [7:0] prev_d = 8'h00;
        logic prev_l = 1'b0;
        @(negedge clk);
        start = 1'b1;
        base_addr = 8'(base);
        len_in = 9'(len);
        @(posedge clk);
        while (done_c < 0 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == inj);
            if (cyc == inj) begin
                base_addr = 8'h00;
                len_in = 9'd3;
            end
            rdy = (mode == 0) ? 1'b1 : rdy_pat[cyc % 16];
            bus.m_ready_i = rdy;
            if (cyc == 1 && len > 0) begin
                check({tag, "_first_addr"}, 32'(bus.ram_addr_o), 32'(base));
                check({tag, "_we"}, 32'(bus.ram_we_o), 32'd0);
            end
            if (prev_stall) begin
                check({tag, "_stall_valid"}, 32'(bus.m_valid_o), 32'd1);
                check({tag, "_stall_data"}, 32'(bus.m_data_o), 32'(prev_d));
                check({tag, "_stall_last"}, 32'(bus.m_last_o), 32'(prev_l));
            end
            if (bus.m_valid_o && first_v < 0) first_v = cyc;
            if (bus.m_valid_o && rdy) begin
                check({tag, "_data"}, 32'(bus.m_data_o), 32'((base + beats) % 256));
                check({tag, "_last"}, 32'(bus.m_last_o), 32'(beats == len - 1));
                beats++;
            end
            prev_stall = bus.m_valid_o && !rdy;
            prev_d = bus.m_data_o;
            prev_l = bus.m_last_o;
            if (done) begin
                done_c = cyc;
                check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(done_c >= 0), 32'd1);
        check({tag, "_beats"}, 32'(beats), 32'(len));
        if (mode == 0) check({tag, "_done_cycle"}, 32'(done_c), 32'((len == 0) ? 1 : len + 3));
        if (mode == 0 && len > 0) check({tag, "_first_valid"}, 32'(first_v), 32'd3);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_valid"}, 32'(bus.m_valid_o), 32'd0);
    endtask

    initial begin
        int cyc;
        int beats;
        int seen_bad;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        rst = 1'b1;
        start = 1'b0;
        base_addr = 8'h00;
        len_in = 9'd0;
        bus.m_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(bus.m_valid_o), 32'd0);
        check("rst_last", 32'(bus.m_last_o), 32'd0);
        check("rst_addr", 32'(bus.ram_addr_o), 32'd0);
        check("rst_we", 32'(bus.ram_we_o), 32'd0);
        rst = 1'b0;

        run_xfer("basic", 8'h10, 4, 0, 0);
        check("idle_addr_hold", 32'(bus.ram_addr_o), 32'h14);
        run_xfer("wrap", 8'hFE, 4, 0, 0);
        run_xfer("bp", 8'h40, 8, 1, 0);
        run_xfer("len0", 8'h33, 0, 0, 0);
        run_xfer("full", 8'h80, 256, 0, 0);
        run_xfer("ign_start", 8'h30, 5, 0, 2);

        // Reset one cycle after the second beat of a 6-word transfer.
        @(negedge clk);
        start = 1'b1;
        base_addr = 8'h50;
        len_in = 9'd6;
        bus.m_ready_i = 1'b1;
        @(posedge clk);
        cyc = 0;
        beats = 0;
        while (beats < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (bus.m_valid_o) begin
                check("rstmid_data", 32'(bus.m_data_o), 32'(8'h50 + beats));
                beats++;
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_valid", 32'(bus.m_valid_o), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        seen_bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || bus.m_valid_o || busy) seen_bad = 1;
        end
        check("rstmid_quiet", 32'(seen_bad), 32'd0);
        run_xfer("after_rst", 8'h20, 2, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
